// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : gshare_predictor
// Purpose  : Conditional-branch direction predictor. It has a table of
//            saturating counters indexed by PC (bimodal) or by PC XOR
//            speculative global history (gshare). An in-order in-flight queue
//            links each IF prediction to its EX resolution and carries the
//            history checkpoint used for mispredict repair.
// Ports    : clk, rst (async, active-high)
//            stall, flush            - pipeline control
//            pred_valid, pred_pc     - IF prediction request
//            pred_ready, pred_taken  - queue has room / predicted direction
//            res_valid, res_taken,
//            res_mispredict          - EX resolution of the oldest branch
//            occupancy               - number of in-flight branches
//            res_error               - sticky: resolve seen with empty queue
// Revision : 1.0 - initial release
// ============================================================================
module gshare_predictor #(
    parameter int INDEX_WIDTH = 10,
    parameter int HR_WIDTH    = 8,
    parameter int CTR_WIDTH   = 2,
    parameter int CTR_INIT    = 1,
    parameter int MODE        = 1,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       pred_valid,
    input  logic [31:0]                pred_pc,
    output logic                       pred_ready,
    output logic                       pred_taken,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic                       res_mispredict,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       res_error
);

    localparam int c_ptr_w      = $clog2(DEPTH);
    localparam int c_occ_w      = c_ptr_w + 1;
    localparam int c_table_size = 1 << INDEX_WIDTH;

    localparam logic [CTR_WIDTH-1:0] c_ctr_init = CTR_WIDTH'(CTR_INIT);
    localparam logic [CTR_WIDTH-1:0] c_ctr_max  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] c_ctr_one  = CTR_WIDTH'(1);
    localparam logic [c_occ_w-1:0]   c_occ_full = c_occ_w'(DEPTH);
    localparam logic [c_occ_w-1:0]   c_occ_one  = c_occ_w'(1);
    localparam logic [c_ptr_w-1:0]   c_ptr_one  = c_ptr_w'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CTR_WIDTH-1:0]   r_table [c_table_size];
    logic [HR_WIDTH-1:0]    r_spec_ghr;
    logic [HR_WIDTH-1:0]    r_commit_ghr;
    logic [INDEX_WIDTH-1:0] r_q_idx [DEPTH];
    logic [HR_WIDTH-1:0]    r_q_ghr [DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_occ_w-1:0]     r_occ;
    logic                   r_res_error;

    // ------------------------------------------------------------------------
    // Index and prediction
    // ------------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] w_pc_idx;
    logic [INDEX_WIDTH-1:0] w_idx;
    logic [CTR_WIDTH-1:0]   w_pred_ctr;

    // Bits of the PC that never take part in indexing.
    logic w_unused_pc;
    assign w_unused_pc = ^{pred_pc[31:INDEX_WIDTH+2], pred_pc[1:0]};

    assign w_pc_idx = pred_pc[INDEX_WIDTH+1:2];

    generate
        if (MODE == 0) begin : g_bimodal
            assign w_idx = w_pc_idx;
        end else begin : g_gshare
            assign w_idx = w_pc_idx ^ INDEX_WIDTH'(r_spec_ghr);
        end
    endgenerate

    // Reads the pre-edge table: a same-cycle update is intentionally not bypassed.
    assign w_pred_ctr = r_table[w_idx];
    assign pred_taken = w_pred_ctr[CTR_WIDTH-1];

    // ------------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_ready;
    logic w_resolve;
    logic w_mispredict;
    logic w_push;

    assign w_empty      = (r_occ == '0);
    // Ready depends on registered occupancy only, so a same-cycle pop never
    // opens a slot for a same-cycle push.
    assign w_ready      = (r_occ != c_occ_full);
    assign w_resolve    = res_valid && !w_empty;
    assign w_mispredict = w_resolve && res_mispredict;
    // Any asserted mispredict suppresses the push, even with an empty queue.
    assign w_push       = pred_valid && w_ready && !stall && !flush
                          && !(res_valid && res_mispredict);

    assign pred_ready = w_ready;
    assign occupancy  = r_occ;
    assign res_error  = r_res_error;

    logic [INDEX_WIDTH-1:0] w_head_idx;
    logic [HR_WIDTH-1:0]    w_head_ghr;

    assign w_head_idx = r_q_idx[r_rd_ptr];
    assign w_head_ghr = r_q_ghr[r_rd_ptr];

    // ------------------------------------------------------------------------
    // History shift values; the truncating cast keeps the youngest HR_WIDTH
    // bits, which also covers HR_WIDTH == 1.
    // ------------------------------------------------------------------------
    logic [HR_WIDTH-1:0] w_spec_shift;
    logic [HR_WIDTH-1:0] w_commit_shift;
    logic [HR_WIDTH-1:0] w_repair_shift;
    logic [HR_WIDTH-1:0] w_commit_next;

    assign w_spec_shift   = HR_WIDTH'({r_spec_ghr, pred_taken});
    assign w_commit_shift = HR_WIDTH'({r_commit_ghr, res_taken});
    assign w_repair_shift = HR_WIDTH'({w_head_ghr, res_taken});
    assign w_commit_next  = w_resolve ? w_commit_shift : r_commit_ghr;

    // ------------------------------------------------------------------------
    // Counter update for the resolving entry
    // ------------------------------------------------------------------------
    logic [CTR_WIDTH-1:0] w_ctr_cur;
    logic [CTR_WIDTH-1:0] w_ctr_next;

    assign w_ctr_cur = r_table[w_head_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (res_taken) begin
            if (w_ctr_cur != c_ctr_max) begin
                w_ctr_next = w_ctr_cur + c_ctr_one;
            end
        end else begin
            if (w_ctr_cur != '0) begin
                w_ctr_next = w_ctr_cur - c_ctr_one;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_table_size; i++) begin
                r_table[i] <= c_ctr_init;
            end
        end else if (w_resolve) begin
            r_table[w_head_idx] <= w_ctr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Global history registers. Flush wins over mispredict repair and picks up
    // the commit history including any same-cycle resolve.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spec_ghr   <= '0;
            r_commit_ghr <= '0;
        end else begin
            r_commit_ghr <= w_commit_next;
            if (flush) begin
                r_spec_ghr <= w_commit_next;
            end else if (w_mispredict) begin
                r_spec_ghr <= w_repair_shift;
            end else if (w_push) begin
                r_spec_ghr <= w_spec_shift;
            end
        end
    end

    // ------------------------------------------------------------------------
    // In-flight queue: payload needs no reset, pointers and count do.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr] <= w_idx;
            r_q_ghr[r_wr_ptr] <= r_spec_ghr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (flush || w_mispredict) begin
            // Everything younger than the resolving branch is wrong-path.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_resolve) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_resolve) begin
                r_occ <= r_occ + c_occ_one;
            end else if (!w_push && w_resolve) begin
                r_occ <= r_occ - c_occ_one;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_error <= 1'b0;
        end else if (res_valid && w_empty) begin
            r_res_error <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised successor to the per-type history predictors. It is a single conditional-branch direction predictor with selectable bimodal or gshare indexing and configurable counter width. It keeps a speculative global history register with in-order checkpoint/repair, and a bounded in-flight queue linking each prediction made in IF to its resolution in EX. It sits beside the RAS in the fetch-stage prediction path.

## Interface
- INDEX_WIDTH, 10: pattern table has 2^INDEX_WIDTH counters.
- HR_WIDTH, 8: global history length.
  - Must satisfy 1 ≤ HR_WIDTH ≤ INDEX_WIDTH.
- CTR_WIDTH, 2: saturating counter width, ≥ 2.
- CTR_INIT, 1: counter reset value.
  - Must be < 2^CTR_WIDTH.
- MODE, 1: index mode.
  - 0 = bimodal: PC only.
  - 1 = gshare: PC XOR history.
- DEPTH, 4: in-flight queue entries.
  - Power of two, ≥ 2.
- clk, input, 1: clock. All state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- stall, input, 1: pipeline stall. Blocks prediction push only; resolve still proceeds.
- flush, input, 1: external flush, e.g. exception.
- pred_valid, input, 1: IF requests a prediction for a branch.
- pred_pc, input, 32: PC of the branch.
- pred_ready, output, 1: queue not full.
- pred_taken, output, 1: combinational prediction for pred_pc.
- res_valid, input, 1: oldest in-flight branch resolved in EX.
- res_taken, input, 1: actual direction.
- res_mispredict, input, 1: EX detected a wrong prediction.
- occupancy, output, $clog2(DEPTH)+1: in-flight count.
- res_error, output, 1: sticky flag, set by a resolve while the queue is empty.

## Operation
- Index:
  - MODE 0: idx = pred_pc[INDEX_WIDTH+1:2].
  - MODE 1: idx = pred_pc[INDEX_WIDTH+1:2] ^ {zeros, spec_ghr}, with spec_ghr zero-extended to INDEX_WIDTH.
- Prediction: pred_taken = table[idx] ≥ 2^(CTR_WIDTH-1), i.e. counter MSB.
  - Pure function of the current table and spec_ghr.
- Push: occurs when pred_valid && pred_ready && !stall && !flush && !(res_valid && res_mispredict).
  - Write {idx, spec_ghr} to the queue tail.
  - spec_ghr <= {spec_ghr[HR_WIDTH-2:0], pred_taken}.
- Resolve: occurs when res_valid and the queue is non-empty.
  - Pop the head entry.
  - Update table[head.idx]: +1 if res_taken, saturating at 2^CTR_WIDTH-1; otherwise -1, saturating at 0.
  - commit_ghr <= {commit_ghr[HR_WIDTH-2:0], res_taken}.
- Mispredict (res_valid && res_mispredict, queue non-empty):
  - After the pop, discard all remaining entries (wrong path); occupancy <= 0.
  - spec_ghr <= {head.ghr[HR_WIDTH-2:0], res_taken}.
  - Any same-cycle push is suppressed.
- Flush: queue cleared and spec_ghr <= commit_ghr, including any same-cycle resolve's new commit_ghr.
  - A same-cycle resolve still updates the table and commit_ghr.
  - Flush overrides mispredict repair.
- Resolve with empty queue: no table or GHR change; res_error <= 1 until rst.
- Queue pointers: read and write pointers wrap modulo DEPTH.
  - occupancy = entries held, 0..DEPTH.
  - pred_ready = occupancy != DEPTH, evaluated on registered state. A simultaneous pop does not raise ready in the same cycle.
- Same-cycle push and non-mispredict resolve: occupancy unchanged.

## Timing
- Prediction latency: 0 cycles (combinational from pred_pc).
  - Reads the pre-edge table. A same-cycle update to the same index is not bypassed.
- Table, GHR, queue and occupancy updates become visible the cycle after the edge.
- Reset values:
  - All counters = CTR_INIT.
  - spec_ghr = commit_ghr = 0.
  - Queue empty, occupancy = 0.
  - pred_ready = 1, res_error = 0.
  - pred_taken reflects CTR_INIT, i.e. 0 at the defaults.
- rst asserted mid-operation: in-flight entries are lost, with no pending update applied.

## Test plan
- Reset, then MODE 0, pred_pc=0x100 resolved taken twice → counter 1→2→3. Third prediction for 0x100 has pred_taken=1. Two not-taken resolves → counter 1 → pred_taken=0.
- Saturation, CTR_WIDTH=3: eight taken resolves on one index → counter holds 7. Eight not-taken resolves → counter holds 0, no wrap.
- Gshare history: predict 0x200 (pred 0), 0x204 (pred 0), 0x208 (pred 0) → spec_ghr=0. Resolve 0x200 with res_taken=1, res_mispredict=1:
  - spec_ghr=0x01 and commit_ghr=0x01.
  - occupancy=0.
  - The next prediction for 0x204 uses idx=(0x204>>2)^1=0x080.
- Full queue, DEPTH=4: 4 pushes → pred_ready=0, occupancy=4. A fifth pred_valid is not pushed. One resolve → next cycle pred_ready=1, occupancy=3.
- Flush with 3 in flight plus a same-cycle non-mispredict resolve → table updated once. commit_ghr shifts in res_taken, spec_ghr equals the new commit_ghr, occupancy=0.
- res_valid with empty queue → res_error=1 and stays high. Table and commit_ghr unchanged. Cleared only by rst.
